enemy_manager: RTL and testbench



---
 rtl/enemy_manager.sv | 155 +++++++++++++++
 tb/tb_enemy_manager.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_manager.sv
// Enemy slot table: spawns, advances and kills enemies,
// counts bottom-row breaches and tracks lives / game over.
module enemy_manager #(
    parameter int         NUM_SLOTS = 8,
    parameter int         NUM_LANES = 8,
    parameter int         ROWS      = 16,
    parameter int         LIVES     = 3,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                                   clk,
    input  logic                                   resetN,
    input  logic                                   run,
    input  logic                                   ice,
    input  logic                                   spawn,
    input  logic                                   advance,
    input  logic                                   kill_valid,
    input  logic [$clog2(NUM_SLOTS)-1:0]           kill_slot,
    output logic [NUM_SLOTS-1:0]                   slot_active,
    output logic [NUM_SLOTS*$clog2(NUM_LANES)-1:0] slot_lane,
    output logic [NUM_SLOTS*$clog2(ROWS)-1:0]      slot_row,
    output logic [$clog2(NUM_SLOTS):0]             active_count,
    output logic                                   breach,
    output logic [7:0]                             lives_left,
    output logic                                   spawn_drop,
    output logic                                   game_over
);

    localparam int SW = $clog2(NUM_SLOTS);
    localparam int CW = SW + 1;
    localparam int LW = $clog2(NUM_LANES);
    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] BOTTOM = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic upd, sp, adv, kl;
    logic [7:0] lfsr_q, lfsr_d;
    logic [NUM_SLOTS-1:0] act_d;
    logic [NUM_SLOTS*LW-1:0] lane_d;
    logic [NUM_SLOTS*RW-1:0] row_d;
    logic [CW-1:0] nbr, cnt_d;
    logic [7:0] lives_d;
    logic drop_d, found;
    logic [SW-1:0] fidx;

    // State register
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: start on run, end when the last life is lost
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (run) state_d = PLAY;
            PLAY: if (upd && nbr != '0 && lives_d == 8'd0)
                      state_d = OVER;
            OVER: state_d = OVER;
            default: state_d = IDLE;
        endcase
    end

    // Per-cycle update enables derived from the state
    always_comb begin
        upd = (state_q == PLAY) && run;
        sp  = upd && spawn && !ice;
        adv = upd && advance && !ice;
        kl  = upd && kill_valid;
    end

    // Next slot table, breach count and spawn allocation
    always_comb begin
        act_d  = slot_active;
        lane_d = slot_lane;
        row_d  = slot_row;
        nbr    = '0;
        found  = 1'b0;
        fidx   = '0;
        drop_d = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_active[i] && !found) begin
                found = 1'b1;
                fidx  = SW'(i);
            end
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_active[i]) begin
                if (kl && kill_slot == SW'(i)) begin
                    act_d[i] = 1'b0;
                end else if (adv) begin
                    if (slot_row[i*RW +: RW] == BOTTOM) begin
                        act_d[i] = 1'b0;
                        nbr      = nbr + CW'(1);
                    end else begin
                        row_d[i*RW +: RW] =
                            slot_row[i*RW +: RW] + RW'(1);
                    end
                end
            end
        end
        if (sp) begin
            if (found) begin
                act_d[fidx]          = 1'b1;
                lane_d[fidx*LW +: LW] = lfsr_q[LW-1:0];
                row_d[fidx*RW +: RW]  = '0;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    // Active count, saturating lives and LFSR step
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            cnt_d = cnt_d + CW'(act_d[i]);
        if (8'(nbr) >= lives_left) lives_d = 8'd0;
        else                       lives_d = lives_left - 8'(nbr);
        lfsr_d = {1'b0, lfsr_q[7:1]}
               ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    end

    // Registered outputs and LFSR
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            slot_active  <= '0;
            slot_lane    <= '0;
            slot_row     <= '0;
            active_count <= '0;
            breach       <= 1'b0;
            spawn_drop   <= 1'b0;
            game_over    <= 1'b0;
            lives_left   <= 8'(LIVES);
            lfsr_q       <= LFSR_SEED;
        end else begin
            slot_active  <= act_d;
            slot_lane    <= lane_d;
            slot_row     <= row_d;
            active_count <= cnt_d;
            breach       <= adv && (nbr != '0);
            spawn_drop   <= drop_d;
            game_over    <= (state_d == OVER);
            lives_left   <= lives_d;
            if (upd) lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: tb/tb_enemy_manager.sv
// Bench for enemy_manager: directed scenarios plus random
// stimulus compared every cycle against a behavioural model.
module tb_enemy_manager;

    logic clk = 1'b0;
    logic resetN = 1'b1;
    logic run = 1'b0, ice = 1'b0, spawn = 1'b0, advance = 1'b0;
    logic kill_valid = 1'b0;
    logic [2:0] kill_slot = 3'd0;
    logic [7:0] slot_active;
    logic [23:0] slot_lane;
    logic [31:0] slot_row;
    logic [3:0] active_count;
    logic breach, spawn_drop, game_over;
    logic [7:0] lives_left;

    int total = 0;
    int bad = 0;

    enemy_manager dut (
        .clk(clk), .resetN(resetN), .run(run), .ice(ice),
        .spawn(spawn), .advance(advance),
        .kill_valid(kill_valid), .kill_slot(kill_slot),
        .slot_active(slot_active), .slot_lane(slot_lane),
        .slot_row(slot_row), .active_count(active_count),
        .breach(breach), .lives_left(lives_left),
        .spawn_drop(spawn_drop), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Behavioural model of the game
    bit m_act[8];
    int m_lane[8];
    int m_row[8];
    int m_lives;
    bit m_play, m_over, m_breach, m_drop;
    logic [7:0] m_lfsr;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_act[i] = 0; m_lane[i] = 0; m_row[i] = 0;
        end
        m_lives = 3; m_play = 0; m_over = 0;
        m_breach = 0; m_drop = 0; m_lfsr = 8'hA5;
    endfunction

    function automatic void model_step();
        int free, nb;
        m_breach = 0; m_drop = 0;
        if (m_over) return;
        if (!m_play) begin
            if (run) m_play = 1;
            return;
        end
        if (!run) return;
        free = -1;
        for (int i = 0; i < 8; i++)
            if (!m_act[i] && free < 0) free = i;
        if (kill_valid && m_act[kill_slot]) m_act[kill_slot] = 0;
        nb = 0;
        if (advance && !ice) begin
            for (int i = 0; i < 8; i++) begin
                if (m_act[i]) begin
                    if (m_row[i] == 15) begin
                        m_act[i] = 0; nb++;
                    end else begin
                        m_row[i]++;
                    end
                end
            end
        end
        if (spawn && !ice) begin
            if (free >= 0) begin
                m_act[free] = 1;
                m_lane[free] = int'(m_lfsr) % 8;
                m_row[free] = 0;
            end else begin
                m_drop = 1;
            end
        end
        m_breach = (nb > 0);
        m_lives = (nb >= m_lives) ? 0 : m_lives - nb;
        if (nb > 0 && m_lives == 0) begin
            m_over = 1; m_play = 0;
        end
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t",
                     nm, got, want, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [7:0] ea;
        logic [23:0] el, lm;
        logic [31:0] er, rm;
        int cnt;
        ea = '0; el = '0; er = '0; lm = '0; rm = '0; cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_act[i]) begin
                ea[i] = 1'b1; cnt++;
                el[i*3 +: 3] = 3'(m_lane[i]);
                er[i*4 +: 4] = 4'(m_row[i]);
                lm[i*3 +: 3] = 3'b111;
                rm[i*4 +: 4] = 4'hF;
            end
        end
        chk("active", 32'(slot_active), 32'(ea));
        chk("count", 32'(active_count), 32'(cnt));
        chk("lane", 32'(slot_lane & lm), 32'(el));
        chk("row", slot_row & rm, er);
        chk("breach", 32'(breach), 32'(m_breach));
        chk("drop", 32'(spawn_drop), 32'(m_drop));
        chk("lives", 32'(lives_left), 32'(m_lives));
        chk("over", 32'(game_over), 32'(m_over));
    end

    task automatic cyc(input bit r, input bit s, input bit a,
                       input bit k, input int ks, input bit ic);
        run = r; spawn = s; advance = a;
        kill_valid = k; kill_slot = 3'(ks); ice = ic;
        @(posedge clk);
        if (!resetN) model_step();
        #1;
    endtask

    task automatic do_reset();
        #2;
        resetN = 1'b1;
        model_reset();
        run = 0; spawn = 0; advance = 0; kill_valid = 0; ice = 0;
        @(posedge clk);
        #1 resetN = 1'b0;
    endtask

    task automatic go_play();
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1 resetN = 1'b0;
        chk("rst_act", 32'(slot_active), 32'h0);
        chk("rst_lane", 32'(slot_lane), 32'h0);
        chk("rst_lives", 32'(lives_left), 32'd3);
        chk("rst_over", 32'(game_over), 32'd0);

        // First spawn uses the seed lane
        go_play();
        cyc(1, 1, 0, 0, 0, 0);
        chk("sp1_act", 32'(slot_active), 32'h01);
        chk("sp1_lane", 32'(slot_lane[2:0]), 32'd5);
        chk("sp1_row", 32'(slot_row[3:0]), 32'd0);
        chk("sp1_cnt", 32'(active_count), 32'd1);

        // Table full, ninth spawn dropped
        do_reset();
        go_play();
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0, 0);
        chk("full_act", 32'(slot_active), 32'hFF);
        cyc(1, 1, 0, 0, 0, 0);
        chk("drop9", 32'(spawn_drop), 32'd1);
        chk("drop9_act", 32'(slot_active), 32'hFF);

        // Walk one enemy to the bottom and off
        do_reset();
        go_play();
        cyc(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc(1, 0, 1, 0, 0, 0);
        chk("row15", 32'(slot_row[3:0]), 32'd15);
        chk("row15_br", 32'(breach), 32'd0);
        cyc(1, 0, 1, 0, 0, 0);
        chk("brk_act", 32'(slot_active), 32'h0);
        chk("brk_br", 32'(breach), 32'd1);
        chk("brk_lives", 32'(lives_left), 32'd2);
        cyc(1, 0, 0, 0, 0, 0);
        chk("brk_pulse", 32'(breach), 32'd0);

        // Kill beats advance at the bottom row
        do_reset();
        go_play();
        cyc(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 1, 0, 0);
        chk("kb_act", 32'(slot_active), 32'h0);
        chk("kb_br", 32'(breach), 32'd0);
        chk("kb_lives", 32'(lives_left), 32'd3);

        // Ice freezes spawn/advance but not kills
        do_reset();
        go_play();
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 1);
        chk("ice_act", 32'(slot_active), 32'h03);
        chk("ice_drop", 32'(spawn_drop), 32'd0);
        chk("ice_row", 32'(slot_row[7:0]), 32'h00);
        cyc(1, 0, 0, 1, 1, 1);
        chk("ice_kill", 32'(slot_active), 32'h01);
        cyc(1, 0, 1, 0, 0, 0);
        chk("thaw_row", 32'(slot_row[3:0]), 32'd1);

        // Three simultaneous breaches end the game
        do_reset();
        go_play();
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        chk("go_lives", 32'(lives_left), 32'd0);
        chk("go_br", 32'(breach), 32'd1);
        chk("go_flag", 32'(game_over), 32'd1);
        cyc(1, 1, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("go_hold", 32'(slot_active), 32'h0);
        chk("go_stay", 32'(game_over), 32'd1);
        do_reset();
        chk("go_rst_l", 32'(lives_left), 32'd3);
        chk("go_rst_o", 32'(game_over), 32'd0);

        // Random play with occasional mid-game resets
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 9) != 0,
                    $urandom_range(0, 9) < 3,
                    $urandom_range(0, 9) < 4,
                    $urandom_range(0, 9) < 2,
                    int'($urandom_range(0, 7)),
                    $urandom_range(0, 9) == 0);
            end
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
